ir_fir_convolver: RTL and testbench
===================================

# ir_fir_convolver

Parametrised, multi-channel, time-domain impulse-response convolver for the guitar effects chain. It sits in the same slot as the FFT-based IR filter: sample in, filtered sample out. It replaces FFT block processing with a sequential single-MAC engine, which gives per-sample latency, a run-time-loadable coefficient RAM and a bypass mode. Channels share one multiplier and are processed back-to-back.

## Interface
Parameters:
- DATA_W, 32, sample and coefficient width (signed fixed point).
- FRAC_W, 12, fractional bits of samples and coefficients.
- TAPS, 64, IR length per channel; power of two, ≥ 2.
- CHANNELS, 1, independent channels; all share one coefficient set.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  input frame valid.
- i_ready  out  1  block can accept a frame.
- i_sample  in  CHANNELS*DATA_W  one sample per channel; channel c is in bits [c*DATA_W +: DATA_W].
- i_bypass  in  1  sampled at accept; pass the input straight through.
- o_valid  out  1  single-cycle pulse; o_sample is valid.
- o_sample  out  CHANNELS*DATA_W  filtered frame; held until the next o_valid.
- i_coef_we  in  1  coefficient write strobe.
- i_coef_addr  in  $clog2(TAPS)  tap index.
- i_coef_data  in  DATA_W  coefficient value.

## Operation
- State machine states: IDLE, MAC, ROUND.
- Accept: the cycle with i_valid && i_ready.
  - Writes each channel sample into its history ring at wr_ptr.
  - Advances wr_ptr modulo TAPS. Wrap from TAPS-1 to 0 is seamless.
- Filtered output: y_c[n] = Σ_{k=0..TAPS-1} h[k]·x_c[n-k].
- MAC: one product per cycle. Order is channel 0 taps 0..TAPS-1, then channel 1, and so on.
  - Accumulator is signed, ACC_W = 2*DATA_W + $clog2(TAPS) bits.
  - Accumulator clears at the start of each channel.
- ROUND, per channel: y = (acc + 2^(FRAC_W-1)) >>> FRAC_W, saturated to the signed DATA_W range.
  - Done as each channel finishes; results are latched into the o_sample slot.
- Bypass (i_bypass=1 at accept):
  - History is still written.
  - o_sample = i_sample, o_valid pulses the next cycle.
  - FSM stays in IDLE and i_ready stays high.
- Coefficient writes:
  - Applied only when the FSM is in IDLE (including the accept cycle; the write takes effect before the MAC starts).
  - Writes in MAC or ROUND are dropped silently.
- Reset values:
  - h[0] = 1<<FRAC_W (1.0); all other h = 0, so the block is identity after reset.
  - History = 0, wr_ptr = 0, FSM = IDLE.
  - i_ready = 1, o_valid = 0, o_sample = 0.
- Reset mid-MAC: the operation is aborted. No o_valid is produced and all reset values are restored on the next cycle.

## Timing
- Filter latency: accept at edge t → o_valid high in cycle t + TAPS*CHANNELS + 1.
  - Example: TAPS=64, CHANNELS=1 → 65 cycles.
- i_ready:
  - Low from the cycle after accept until o_valid.
  - Rises together with o_valid, so a new frame can be accepted in the o_valid cycle.
  - Throughput: one frame per TAPS*CHANNELS + 1 cycles.
- Bypass latency: 1 cycle; back-to-back frames are accepted every cycle.
- No output backpressure: o_valid is a pulse, and o_sample is stable between pulses.
- i_valid while i_ready=0 is ignored; the frame is not queued.
- Coefficient and history storage are synchronous-read RAMs. The read is issued one cycle ahead of the MAC use; the pipeline registers are internal to the latency above.

## Structure
- Package ir_fir_pkg holds:
  - state_t enum {IDLE, MAC, ROUND};
  - acc_width(DATA_W, TAPS) function;
  - the identity-coefficient constant.
- Sub-module fxp_round_sat (ACC_W in, DATA_W out, FRAC_W): combinational rounding and saturation, reused by other effects.
- History storage: one TAPS×DATA_W RAM per channel, or a single CHANNELS*TAPS RAM addressed {ch, ptr}.

## Test plan
- Identity after reset: frames 100, -7, 32767 → outputs 100, -7, 32767; o_valid 65 cycles after each accept (TAPS=64).
- Impulse response: load h[k]=k<<12 for k<8; feed 1<<12 then zeros → outputs k<<12 for k=0..7, then 0.
- Saturation: h[0..3]=1<<12, four samples of 0x7FFF_FFFF → output saturates at 0x7FFF_FFFF; with negative inputs it saturates at 0x8000_0000.
- Bypass back-to-back: i_bypass=1, 5 frames on consecutive cycles → 5 o_valid pulses, each 1 cycle later with equal data. The next non-bypass frame sees that history.
- Coefficient write during MAC is dropped: write h[0]=0 mid-MAC → current and next outputs still use h[0]=1.0.
- Reset mid-MAC at cycle 30 → no o_valid; i_ready=1 the next cycle; the next frame 5 → output 5.
- CHANNELS=2: frame {ch1=3, ch0=-4} → {3, -4}; latency 129 cycles.

Source files
------------

// File: rtl/ir_fir_pkg.sv
// Shared types and helpers for the time-domain IR convolver and its
// fixed-point building blocks.
package ir_fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } state_t;

  // Index of the tap that carries 1.0 in the identity impulse response.
  localparam int unsigned IDENTITY_TAP = 0;

  // The accumulator holds TAPS full-width products without overflow.
  function automatic int acc_width(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic logic [63:0] identity_coef(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Round-half-up a wide signed accumulator by FRAC_W bits and saturate
// the result to the signed DATA_W range.
module fxp_round_sat #(
  parameter int ACC_W  = 70,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 12
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  // One extra bit keeps the rounding add from overflowing at the top of the range.
  localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W:0] MAX_EXT = (ACC_W + 1)'({1'b0, {(DATA_W - 1){1'b1}}});
  localparam logic signed [ACC_W:0] MIN_EXT = -MAX_EXT - (ACC_W + 1)'(1);

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    biased  = {acc[ACC_W-1], acc} + HALF;
    shifted = biased >>> FRAC_W;
    if (shifted > MAX_EXT) begin
      y = MAX_EXT[DATA_W-1:0];
    end else if (shifted < MIN_EXT) begin
      y = MIN_EXT[DATA_W-1:0];
    end else begin
      y = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ir_fir_convolver.sv
// Multi-channel sequential single-MAC impulse-response convolver with a
// run-time loadable coefficient RAM and a one-cycle bypass path.
module ir_fir_convolver
  import ir_fir_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 12,
  parameter int TAPS     = 64,
  parameter int CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [CHANNELS*DATA_W-1:0]   i_sample,
  input  logic                         i_bypass,
  output logic                         o_valid,
  output logic [CHANNELS*DATA_W-1:0]   o_sample,
  input  logic                         i_coef_we,
  input  logic [$clog2(TAPS)-1:0]      i_coef_addr,
  input  logic [DATA_W-1:0]            i_coef_data
);

  localparam int PTR_W = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = acc_width(DATA_W, TAPS);

  localparam logic [DATA_W-1:0]  H_ONE   = DATA_W'(identity_coef(FRAC_W));
  localparam logic [PTR_W-1:0]   K_LAST  = PTR_W'(TAPS - 1);
  localparam logic [PTR_W-1:0]   K_PRE   = PTR_W'(TAPS - 2);
  localparam logic [CH_W-1:0]    CH_LAST = CH_W'(CHANNELS - 1);

  state_t state, state_nxt;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] base_ptr;
  logic [PTR_W-1:0] mac_k;
  logic [CH_W-1:0]  mac_ch;
  logic [PTR_W-1:0] rd_k;
  logic [PTR_W-1:0] rd_ptr;
  logic [CH_W-1:0]  rd_ch;

  logic accept;
  logic filt_start;
  logic coef_wr;

  logic signed [DATA_W-1:0]   coef_mem [TAPS];
  logic signed [DATA_W-1:0]   hist_mem [CHANNELS][TAPS];
  logic signed [DATA_W-1:0]   coef_q;
  logic signed [DATA_W-1:0]   hist_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_nxt;
  logic signed [DATA_W-1:0]   y_rnd;
  logic [DATA_W-1:0]          res_q [CHANNELS];

  assign i_ready    = (state == IDLE);
  assign accept     = i_valid && i_ready;
  assign filt_start = accept && !i_bypass;
  assign coef_wr    = i_coef_we && (state == IDLE);

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no path leaves a signal unassigned and no latch appears.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (filt_start) state_nxt = MAC;
      MAC:     if (mac_k == K_PRE) state_nxt = ROUND;
      ROUND:   state_nxt = (mac_ch == CH_LAST) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // Read address runs one product ahead of the accumulate stage; in IDLE it
  // points at tap 0 of the sample being accepted.
  always_comb begin
    rd_k   = mac_k + 1'b1;
    rd_ch  = mac_ch;
    rd_ptr = base_ptr - rd_k;
    if (state == IDLE) begin
      rd_k   = '0;
      rd_ch  = '0;
      rd_ptr = wr_ptr;
    end else if (mac_k == K_LAST && mac_ch != CH_LAST) begin
      rd_ch = mac_ch + 1'b1;
    end
  end

  // NOTE: these RAMs carry a reset because the block must come out of reset
  // as an identity filter with clean history; read registers need none.
  always_ff @(posedge clk) begin
    coef_q <= (coef_wr && i_coef_addr == rd_k) ? i_coef_data : coef_mem[rd_k];
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_mem[k] <= (k == IDENTITY_TAP) ? H_ONE : '0;
      end
    end else if (coef_wr) begin
      coef_mem[i_coef_addr] <= i_coef_data;
    end
  end

  // Accept only happens in IDLE, where the read targets channel 0 at wr_ptr.
  always_ff @(posedge clk) begin
    hist_q <= accept ? i_sample[DATA_W-1:0] : hist_mem[rd_ch][rd_ptr];
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          hist_mem[c][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        hist_mem[c][wr_ptr] <= i_sample[c*DATA_W +: DATA_W];
      end
    end
  end

  assign prod    = coef_q * hist_q;
  assign acc_nxt = ((mac_k == '0) ? '0 : acc)
                 + {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  fxp_round_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .acc (acc_nxt),
    .y   (y_rnd)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      base_ptr <= '0;
      mac_k    <= '0;
      mac_ch   <= '0;
      acc      <= '0;
      o_valid  <= 1'b0;
      o_sample <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        res_q[c] <= '0;
      end
    end else begin
      state   <= state_nxt;
      o_valid <= 1'b0;
      if (accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        base_ptr <= wr_ptr;
        mac_k    <= '0;
        mac_ch   <= '0;
        if (i_bypass) begin
          o_sample <= i_sample;
          o_valid  <= 1'b1;
        end
      end
      if (state != IDLE) begin
        acc   <= acc_nxt;
        mac_k <= mac_k + 1'b1;
        if (state == ROUND) begin
          if (mac_ch == CH_LAST) begin
            // Earlier channels were staged so o_sample changes only with o_valid.
            for (int c = 0; c < CHANNELS - 1; c++) begin
              o_sample[c*DATA_W +: DATA_W] <= res_q[c];
            end
            o_sample[(CHANNELS-1)*DATA_W +: DATA_W] <= y_rnd;
            o_valid <= 1'b1;
          end else begin
            res_q[mac_ch] <= y_rnd;
            mac_ch        <= mac_ch + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_fir_convolver.sv
// Directed bench for ir_fir_convolver: identity, impulse, saturation,
// bypass, dropped coefficient writes, mid-MAC reset and two channels.
module tb_ir_fir_convolver;

  localparam int DW   = 32;
  localparam int TAPS = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [DW-1:0] i_sample = '0;
  logic          i_bypass = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_sample;
  logic          i_coef_we = 1'b0;
  logic [5:0]    i_coef_addr = '0;
  logic [DW-1:0] i_coef_data = '0;

  logic            v2 = 1'b0;
  logic            rdy2;
  logic [2*DW-1:0] s2 = '0;
  logic            ov2;
  logic [2*DW-1:0] os2;
  logic            we2 = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ir_fir_convolver #(.DATA_W(DW), .FRAC_W(12), .TAPS(TAPS), .CHANNELS(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_sample(i_sample), .i_bypass(i_bypass), .o_valid(o_valid),
    .o_sample(o_sample), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
    .i_coef_data(i_coef_data)
  );

  ir_fir_convolver #(.DATA_W(DW), .FRAC_W(12), .TAPS(TAPS), .CHANNELS(2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(v2), .i_ready(rdy2),
    .i_sample(s2), .i_bypass(1'b0), .o_valid(ov2),
    .o_sample(os2), .i_coef_we(we2), .i_coef_addr(6'd0),
    .i_coef_data(32'd0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [5:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    i_coef_we   = 1'b1;
    i_coef_addr = addr;
    i_coef_data = data;
    @(posedge clk);
    #1;
    i_coef_we = 1'b0;
  endtask

  // Sends one frame and waits (bounded) for o_valid. mid_wr=1 pulses a
  // write of h[0]=0 ten cycles into the MAC.
  task automatic run_frame(input string tag, input logic [DW-1:0] s, input bit byp,
                           input int exp_lat, input bit mid_wr, output logic [DW-1:0] got);
    int t0;
    int n;
    @(negedge clk);
    i_sample = s;
    i_bypass = byp;
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_bypass = 1'b0;
    t0 = cyc;
    n  = 0;
    while (!o_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (mid_wr && n == 10) begin
        i_coef_we   = 1'b1;
        i_coef_addr = 6'd0;
        i_coef_data = '0;
      end else begin
        i_coef_we = 1'b0;
      end
    end
    i_coef_we = 1'b0;
    check({tag, "_lat"}, 64'(cyc - t0 + 1), 64'(exp_lat));
    got = o_sample;
  endtask

  logic [DW-1:0] got;
  logic [DW-1:0] vals [5];
  int            t0;
  int            n;
  int            pulses;

  initial begin
    vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30; vals[3] = 32'd40; vals[4] = 32'd50;
    do_reset();

    // Reset state
    check("rst_ready", 64'(i_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_sample", 64'(o_sample), 64'd0);
    check("rst_ready2", 64'(rdy2), 64'd1);

    // Identity after reset, with i_ready low during the MAC
    @(negedge clk);
    i_sample = 32'd100;
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("busy_ready", 64'(i_ready), 64'd0);
    t0 = cyc;
    n  = 0;
    while (!o_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("id0_lat", 64'(cyc - t0 + 1), 64'd65);
    check("id0", 64'(o_sample), 64'd100);
    check("id0_ready", 64'(i_ready), 64'd1);
    run_frame("id1", -32'sd7, 1'b0, 65, 1'b0, got);
    check("id1", 64'(got), 64'(32'hFFFF_FFF9));
    run_frame("id2", 32'd32767, 1'b0, 65, 1'b0, got);
    check("id2", 64'(got), 64'd32767);

    // Impulse response: h[k] = k<<12
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(6'(k), DW'(k << 12));
    for (int m = 0; m < 9; m++) begin
      run_frame("imp", (m == 0) ? 32'd4096 : 32'd0, 1'b0, 65, 1'b0, got);
      check($sformatf("imp%0d", m), 64'(got), (m < 8) ? 64'(m << 12) : 64'd0);
    end

    // Saturation, positive then negative
    do_reset();
    for (int k = 1; k < 4; k++) write_coef(6'(k), 32'd4096);
    for (int m = 0; m < 4; m++) begin
      run_frame("satp", 32'h7FFF_FFFF, 1'b0, 65, 1'b0, got);
      if (m == 0 || m == 3) check($sformatf("satp%0d", m), 64'(got), 64'(32'h7FFF_FFFF));
    end
    for (int m = 0; m < 4; m++) begin
      run_frame("satn", 32'h8000_0000, 1'b0, 65, 1'b0, got);
    end
    check("satn3", 64'(got), 64'(32'h8000_0000));

    // Bypass, five frames back to back
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_valid  = 1'b1;
      i_bypass = 1'b1;
      i_sample = vals[i];
      @(posedge clk);
      #1;
      check($sformatf("byp%0d_valid", i), 64'(o_valid), 64'd1);
      check($sformatf("byp%0d_data", i), 64'(o_sample), 64'(vals[i]));
      check($sformatf("byp%0d_ready", i), 64'(i_ready), 64'd1);
    end
    @(negedge clk);
    i_valid  = 1'b0;
    i_bypass = 1'b0;
    @(posedge clk);
    #1;
    check("byp_end_valid", 64'(o_valid), 64'd0);
    write_coef(6'd1, 32'd4096);
    run_frame("byp_hist", 32'd7, 1'b0, 65, 1'b0, got);
    check("byp_hist", 64'(got), 64'd57);

    // Coefficient write during the MAC is dropped
    do_reset();
    run_frame("cw0", 32'd9, 1'b0, 65, 1'b1, got);
    check("cw0", 64'(got), 64'd9);
    run_frame("cw1", 32'd11, 1'b0, 65, 1'b0, got);
    check("cw1", 64'(got), 64'd11);

    // Reset 30 cycles into the MAC
    @(negedge clk);
    i_sample = 32'd9;
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_ready", 64'(i_ready), 64'd1);
    check("mrst_valid", 64'(o_valid), 64'd0);
    check("mrst_sample", 64'(o_sample), 64'd0);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) pulses++;
    end
    check("mrst_pulses", 64'(pulses), 64'd0);
    run_frame("mrst_next", 32'd5, 1'b0, 65, 1'b0, got);
    check("mrst_next", 64'(got), 64'd5);

    // Two channels sharing one MAC
    @(negedge clk);
    s2 = {32'd3, 32'hFFFF_FFFC};
    v2 = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    check("ch2_busy", 64'(rdy2), 64'd0);
    t0 = cyc;
    n  = 0;
    while (!ov2 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ch2_lat", 64'(cyc - t0 + 1), 64'd129);
    check("ch2_data", os2, {32'd3, 32'hFFFF_FFFC});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
